// File: rtl/led_scan_if.sv
// Bus between a display-data producer and led_scan_ctrl: hex word load side
// plus the decoder code, anode selects and frame pulse on the output side.
interface led_scan_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] i_data;
    logic [DIGITS-1:0]   i_dp;
    logic                i_load;
    logic [4:0]          o_dig_ctrl;
    logic [DIGITS-1:0]   o_dig_an;
    logic                o_frame_done;

    modport master (output i_data, i_dp, i_load,
                    input  o_dig_ctrl, o_dig_an, o_frame_done);
    modport slave  (input  i_data, i_dp, i_load,
                    output o_dig_ctrl, o_dig_an, o_frame_done);
endinterface

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-boundary data swap
// and anti-ghosting blank. Define LED_SCAN_LZS_EN for leading-zero suppression.
module led_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input logic clk,
    input logic rst_n,
    led_scan_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);

    typedef enum logic {BLANK, SHOW} st_t;

    st_t                   st, st_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [IW-1:0]         idx, idx_nx;
    logic [DIGITS-1:0][3:0] pend_data, act_data, act_data_nx, in_data;
    logic [DIGITS-1:0]     pend_dp, act_dp, act_dp_nx;
    logic                  pend_vld;
    logic                  slot_end, frame_end;
    logic [DIGITS-1:0]     lit_nx, an_nx, dig_an;
    logic [4:0]            dig_ctrl;
    logic                  frame_done;

    assign in_data = bus.i_data;

    always_comb begin
        slot_end    = (cnt == CW'(SCAN_DIV-1));
        frame_end   = slot_end && (idx == IW'(DIGITS-1));
        cnt_nx      = slot_end ? '0 : cnt + 1'b1;
        idx_nx      = idx;
        if (slot_end)
            idx_nx = (idx == IW'(DIGITS-1)) ? '0 : idx + 1'b1;
        st_nx = st;
        case (st)
            BLANK: if (cnt == CW'(BLANK_CYC-1)) st_nx = SHOW;
            SHOW:  if (slot_end) st_nx = BLANK;
            default: st_nx = BLANK;
        endcase
        // A load landing on the frame-end cycle bypasses the pending stage
        act_data_nx = act_data;
        act_dp_nx   = act_dp;
        if (frame_end) begin
            if (bus.i_load) begin
                act_data_nx = in_data;
                act_dp_nx   = bus.i_dp;
            end else if (pend_vld) begin
                act_data_nx = pend_data;
                act_dp_nx   = pend_dp;
            end
        end
    end

`ifdef LED_SCAN_LZS_EN
    // hi_zero[g]: digit g and every digit above it are blank with no dp
    logic [DIGITS:1] hi_zero;
    assign hi_zero[DIGITS] = 1'b1;
    for (genvar g = 1; g < DIGITS; g++) begin : g_lzs
        assign hi_zero[g] = hi_zero[g+1] & (act_data_nx[g] == 4'h0) & ~act_dp_nx[g];
    end
    assign lit_nx = {~hi_zero[DIGITS-1:1], 1'b1};
`else
    assign lit_nx = '1;
`endif

    always_comb begin
        an_nx = '1;
        if (st_nx == SHOW && lit_nx[idx_nx])
            an_nx[idx_nx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_vld   <= 1'b0;
            dig_an     <= '1;
            dig_ctrl   <= 5'h00;
            frame_done <= 1'b0;
        end else begin
            st       <= st_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            act_data <= act_data_nx;
            act_dp   <= act_dp_nx;
            if (bus.i_load && !frame_end) begin
                pend_data <= in_data;
                pend_dp   <= bus.i_dp;
                pend_vld  <= 1'b1;
            end else if (frame_end) begin
                pend_vld  <= 1'b0;
            end
            dig_an <= an_nx;
            if (slot_end)
                dig_ctrl <= {act_dp_nx[idx_nx], act_data_nx[idx_nx]};
            frame_done <= (cnt_nx == CW'(SCAN_DIV-1)) && (idx_nx == IW'(DIGITS-1));
        end
    end

    assign bus.o_dig_an     = dig_an;
    assign bus.o_dig_ctrl   = dig_ctrl;
    assign bus.o_frame_done = frame_done;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: directed and random loads/resets compared each
// cycle against a frame-level reference model driven by elapsed time.
module tb_led_scan_ctrl;
    localparam int D = 4;
    localparam int S = 8;
    localparam int B = 2;
    localparam int F = D * S;

    logic clk;
    logic rst_n;
    led_scan_if #(.DIGITS(D)) bus ();

    led_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYC(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errs = 0;
    int          checks = 0;
    int          t;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_actdp, m_penddp;
    logic        m_pv;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s t=%0d: got %0h want %0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; m_act = '0; m_pend = '0; m_actdp = '0; m_penddp = '0; m_pv = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge, advance model at the edge
    task automatic cyc(input bit r, input bit ld, input logic [15:0] d, input logic [3:0] p);
        int          slot, ph;
        logic [3:0]  exp_an;
        logic [4:0]  exp_ctrl;
        logic [15:0] sh;
        rst_n = r; bus.i_load = ld; bus.i_data = d; bus.i_dp = p;
        @(negedge clk);
        slot = (t / S) % D;
        ph   = t % S;
        exp_an = 4'hF;
        if (ph >= B) begin
            exp_an = ~(4'b0001 << slot);
`ifdef LED_SCAN_LZS_EN
            sh = m_act >> (4 * slot);
            if (slot != 0 && sh == 16'h0 && (m_actdp >> slot) == 4'h0)
                exp_an = 4'hF;
`endif
        end
        sh = m_act >> (4 * slot);
        exp_ctrl = {m_actdp[slot], sh[3:0]};
        chk("dig_an",     16'(bus.o_dig_an),     16'(exp_an));
        chk("dig_ctrl",   16'(bus.o_dig_ctrl),   16'(exp_ctrl));
        chk("frame_done", 16'(bus.o_frame_done), 16'((t % F) == F - 1));
        chk("pend_vld",   16'(dut.pend_vld),     16'(m_pv));
        if (!r) begin
            model_reset();
        end else begin
            if ((t % F) == F - 1) begin
                if (ld) begin m_act = d; m_actdp = p; end
                else if (m_pv) begin m_act = m_pend; m_actdp = m_penddp; end
                m_pv = 1'b0;
            end else if (ld) begin
                m_pend = d; m_penddp = p; m_pv = 1'b1;
            end
            t++;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_to(input int target);
        while (t < target) cyc(1'b1, 1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0; bus.i_load = 1'b0; bus.i_data = '0; bus.i_dp = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // idle, then mid-frame load shown from cycle 32
        run_to(5);
        cyc(1'b1, 1'b1, 16'h1A2F, 4'b0100);
        run_to(63);
        // load exactly on frame end goes straight to active
        cyc(1'b1, 1'b1, 16'h4321, 4'b0000);
        run_to(70);
        cyc(1'b1, 1'b1, 16'h1111, 4'b0000);
        run_to(80);
        cyc(1'b1, 1'b1, 16'h2222, 4'b0000);
        run_to(130);
        cyc(1'b1, 1'b1, 16'h0050, 4'b0000);
        run_to(200);
        cyc(1'b1, 1'b1, 16'h0000, 4'b0000);
        run_to(260);
        cyc(1'b1, 1'b1, 16'h00A0, 4'b0100);
        run_to(330);
        // reset mid-slot: SHOW phase of digit 1 at cycle 13
        cyc(1'b0, 1'b0, 16'h0, 4'h0);
        cyc(1'b1, 1'b1, 16'h9876, 4'b1001);
        run_to(13);
        cyc(1'b0, 1'b0, 16'h0, 4'h0);
        run_to(40);
        // random loads with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0)
                cyc(1'b0, 1'b0, 16'h0, 4'h0);
            else if ($urandom_range(0, 7) == 0)
                cyc(1'b1, 1'b1, 16'($urandom), 4'($urandom));
            else
                cyc(1'b1, 1'b0, 16'($urandom), 4'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Time-multiplexed scan controller for a bank of 7-segment digits. It sits directly upstream of the 5-bit-to-segment decoder. Each clock slot it drives the decoder's `{dp, nibble}` code for one digit and asserts the matching common-anode select. It takes a full-display hex word through a load strobe and applies new data only at frame boundaries, so a frame is never torn. It inserts a ghosting blank at every digit change.

## Interface
Parameters:
- `DIGITS`, 8: number of multiplexed digits (2..8).
- `SCAN_DIV`, 50000: clock cycles per digit slot (≥ 4).
- `BLANK_CYC`, 16: anode-off cycles at the start of each slot (1 ≤ `BLANK_CYC` < `SCAN_DIV`).

Ports:
- `clk`, in, 1: system clock. There is one clock; all logic is on its rising edge.
- `rst_n`, in, 1: reset. Synchronous and active-low.
- `i_data`, in, 4*`DIGITS`: hex nibbles. Digit k is `i_data[4k+3:4k]`; digit 0 is the rightmost.
- `i_dp`, in, `DIGITS`: decimal-point request per digit.
- `i_load`, in, 1: single-cycle strobe that samples `i_data`/`i_dp`.
- `o_dig_ctrl`, out, 5: decoder input `{dp, nibble}` for the current digit.
- `o_dig_an`, out, `DIGITS`: digit select, active-low, registered. At most one bit is low at any time.
- `o_frame_done`, out, 1: one-cycle pulse on the last cycle of the last slot.

## Operation
- Registers:
  - Pending: `pend_data`, `pend_dp`, `pend_vld`.
  - Active: `act_data`, `act_dp`.
  - Slot counter `cnt` (0..`SCAN_DIV`-1).
  - Digit index `idx` (0..`DIGITS`-1).
  - State `st` ∈ {BLANK, SHOW}.
- FSM:
  - BLANK: `o_dig_an` is all ones. When `cnt == BLANK_CYC-1`, go to SHOW.
  - SHOW: `o_dig_an[idx]` = 0 and all other bits are 1. When `cnt == SCAN_DIV-1`, go to BLANK, clear `cnt`, and set `idx` to `(idx+1) mod DIGITS`.
- `o_dig_ctrl` = `{act_dp[idx], act_data[idx]}`. It is registered and updates on the first cycle of each slot (entry into BLANK).
- Load: `i_load` = 1 captures the inputs into the pending registers and sets `pend_vld`. A later `i_load` before the frame end overwrites the pending registers; only the last value is kept.
- Frame end is the cycle with `idx == DIGITS-1 && cnt == SCAN_DIV-1`. On that cycle:
  - If `pend_vld`, copy pending to active and clear `pend_vld`.
  - If `i_load` is also high on that cycle, `i_data`/`i_dp` go straight to the active registers and `pend_vld` is left 0.
  - `o_frame_done` pulses.
- Digit index wrap: `DIGITS-1` → 0. The counter is `$clog2(SCAN_DIV)` bits wide and compares for equality only.
- Reset during operation abandons the current slot and drops pending data. The controller restarts at BLANK, `idx` 0, `cnt` 0.

## Timing
- Reset values:
  - `o_dig_an` all ones, `o_dig_ctrl` 5'h00, `o_frame_done` 0.
  - Active and pending data 0, `pend_vld` 0, `st` BLANK, `idx` 0, `cnt` 0.
- The decoder registers its input, so it has 1 cycle of latency. Because `BLANK_CYC` ≥ 1, segments are always settled before the anode turns on. No extra alignment is needed.
- Slot length is exactly `SCAN_DIV` cycles. Frame length is `DIGITS*SCAN_DIV` cycles. Anode-low time per slot is `SCAN_DIV-BLANK_CYC` cycles.
- Load-to-display latency is variable, at most one frame. New data first appears on `o_dig_ctrl` in the cycle after the frame end, for digit 0.
- First slot after reset release: `cnt` starts counting on the first cycle with `rst_n` = 1.

## Configuration
- `LED_SCAN_LZS_EN` (leading-zero suppression):
  - When defined: during SHOW, `o_dig_an[idx]` stays 1 if every digit j ≥ `idx` has `act_data[j]` = 0 and `act_dp[j]` = 0. Digit 0 is never suppressed. Slot timing and `o_dig_ctrl` are unchanged.
  - When undefined: all digits are always shown.

## Test plan
Bench parameters: `DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYC`=2.
- Reset then idle:
  - Stimulus: reset, no load.
  - Required: `o_dig_an` is 4'b1111 for cycles 0–1 and 4'b1110 for cycles 2–7. `o_dig_ctrl` = 5'h00. `o_frame_done` pulses at cycle 31 and every 32 cycles after.
- Load mid-frame:
  - Stimulus: `i_data`=16'h1A2F, `i_dp`=4'b0100 at cycle 5.
  - Required: the old data (0) is shown until cycle 31. The slots starting at cycle 32 show 5'h0F, 5'h02, 5'h1A, 5'h01.
- Load on the frame-end cycle:
  - Stimulus: `i_load` with 16'h4321 exactly on the frame-end cycle.
  - Required: the next slot shows 5'h01 and `pend_vld` = 0.
- Double load:
  - Stimulus: 16'h1111 then 16'h2222 in the same frame.
  - Required: only 16'h2222 is ever displayed.
- Reset mid-slot:
  - Stimulus: `rst_n` low at cycle 13 (in SHOW for digit 1).
  - Required: the next cycle has `o_dig_an` = 4'b1111 and `o_dig_ctrl` = 0. Digit 0 gets a full slot after release.
- `LED_SCAN_LZS_EN` defined, data 16'h0050:
  - Required: digits 3 and 2 keep their anodes high; digits 1 and 0 are lit. With data 16'h0000, only digit 0 is lit.
